// File: rtl/rc_qp_update.sv
// Rate-control QP update: diffBits -> mode/idx (S1), table delta + clamped QP accumulate (S2); 2-cycle latency.
// Valid/ready both sides, 1 block/cycle; in_ready drops when S1 is full and S2 is stalled or slice_start is high.
module rc_qp_update #(
   parameter int BITS_W = 16,
   parameter int DIFF_W = 9,
   parameter int FULL_W = 16,
   parameter int QP_W   = 7,
   parameter int TH_HI2 = 57672,
   parameter int TH_HI1 = 49807,
   parameter int TH_LO4 = 7864,
   parameter int TH_LO3 = 15729
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              slice_start,
   input  logic [QP_W-1:0]   qp_init,
   input  logic [QP_W-1:0]   qp_min,
   input  logic [QP_W-1:0]   qp_max,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BITS_W-1:0] bits_used,
   input  logic [BITS_W-1:0] target_bits,
   input  logic [FULL_W-1:0] rc_fullness,
   input  logic              cfg_we,
   input  logic [5:0]        cfg_addr,
   input  logic [3:0]        cfg_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [QP_W-1:0]   out_qp,
   output logic [3:0]        out_delta
);

   localparam logic [3:0] INC_DEF [0:29] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
      4'h1, 4'h2, 4'h3, 4'h5, 4'h5, 4'h6,
      4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h7,
      4'hF, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2,
      4'hE, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1};
   localparam logic [3:0] DEC_DEF [0:24] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'hF, 4'h0, 4'h0, 4'h1, 4'h1,
      4'hE, 4'hE, 4'h0, 4'h1, 4'h1,
      4'h1, 4'h1, 4'h2, 4'h4, 4'h4,
      4'h2, 4'h2, 4'h4, 4'h5, 4'h5};

   localparam logic signed [BITS_W:0] SAT_HI = (BITS_W+1)'((1 << (DIFF_W-1)) - 1);
   localparam logic signed [BITS_W:0] SAT_LO = ~SAT_HI;

   logic [3:0]        r_inc [0:29];
   logic [3:0]        r_dec [0:24];
   logic              r_s1_vld;
   logic              r_s1_pos;
   logic [2:0]        r_s1_mode;
   logic [2:0]        r_s1_idx;
   logic [QP_W-1:0]   r_qp;
   logic              r_out_vld;

   logic signed [BITS_W:0]   w_diff_full;
   logic signed [DIFF_W-1:0] w_diff;
   logic                     w_pos;
   logic [DIFF_W-1:0]        w_abs;
   logic [2:0]               w_mode;
   logic [2:0]               w_idx;
   logic [4:0]               w_inc_sel;
   logic [4:0]               w_dec_sel;
   logic [3:0]               w_delta;
   logic signed [QP_W+1:0]   w_qp_sum;
   logic [QP_W-1:0]          w_qp_next;
   logic [QP_W-1:0]          w_qp_init_c;
   logic                     w_s2_load;
   logic                     w_accept;

   // S1 classification of the incoming block
   always_comb begin
      w_diff_full = $signed({1'b0, bits_used}) - $signed({1'b0, target_bits});
      if (w_diff_full > SAT_HI)      w_diff = SAT_HI[DIFF_W-1:0];
      else if (w_diff_full < SAT_LO) w_diff = SAT_LO[DIFF_W-1:0];
      else                           w_diff = w_diff_full[DIFF_W-1:0];
      w_pos = !w_diff[DIFF_W-1] && (w_diff != '0);
      w_abs = w_pos ? w_diff : -w_diff;

      if (rc_fullness >= FULL_W'(TH_HI2))      w_mode = 3'd2;
      else if (rc_fullness >= FULL_W'(TH_HI1)) w_mode = 3'd1;
      else if (rc_fullness <= FULL_W'(TH_LO4)) w_mode = 3'd4;
      else if (rc_fullness <= FULL_W'(TH_LO3)) w_mode = 3'd3;
      else                                     w_mode = 3'd0;

      if (w_pos)
         w_idx = 3'(w_abs >= DIFF_W'(10)) + 3'(w_abs >= DIFF_W'(29)) + 3'(w_abs >= DIFF_W'(50))
               + 3'(w_abs >= DIFF_W'(60)) + 3'(w_abs >= DIFF_W'(70));
      else
         w_idx = 3'(w_abs >= DIFF_W'(10)) + 3'(w_abs >= DIFF_W'(20)) + 3'(w_abs >= DIFF_W'(35))
               + 3'(w_abs >= DIFF_W'(65));
   end

   // S2 lookup reads the live tables, so a write is visible the cycle after it lands
   always_comb begin
      w_inc_sel = 5'(r_s1_mode) * 5'd6 + 5'(r_s1_idx);
      w_dec_sel = 5'(r_s1_mode) * 5'd5 + 5'(r_s1_idx);
      w_delta   = r_s1_pos ? r_inc[w_inc_sel] : 4'd0 - r_dec[w_dec_sel];
      w_qp_sum  = $signed({2'b00, r_qp}) + $signed({{(QP_W-2){w_delta[3]}}, w_delta});
      if (w_qp_sum < $signed({2'b00, qp_min}))      w_qp_next = qp_min;
      else if (w_qp_sum > $signed({2'b00, qp_max})) w_qp_next = qp_max;
      else                                          w_qp_next = w_qp_sum[QP_W-1:0];

      if (qp_init < qp_min)      w_qp_init_c = qp_min;
      else if (qp_init > qp_max) w_qp_init_c = qp_max;
      else                       w_qp_init_c = qp_init;
   end

   assign w_s2_load = r_s1_vld && (!r_out_vld || out_ready);
   assign in_ready  = (!r_s1_vld || w_s2_load) && !slice_start;
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 30; i++) r_inc[i] <= INC_DEF[i];
         for (int i = 0; i < 25; i++) r_dec[i] <= DEC_DEF[i];
      end else if (cfg_we) begin
         if (!cfg_addr[5] && cfg_addr[4:0] < 5'd30) r_inc[cfg_addr[4:0]] <= cfg_data;
         if (cfg_addr[5] && cfg_addr[4:0] < 5'd25)  r_dec[cfg_addr[4:0]] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_pos  <= 1'b0;
         r_s1_mode <= 3'd0;
         r_s1_idx  <= 3'd0;
         r_out_vld <= 1'b0;
         r_qp      <= '0;
         out_qp    <= '0;
         out_delta <= 4'd0;
      end else if (slice_start) begin
         r_s1_vld  <= 1'b0;
         r_out_vld <= 1'b0;
         r_qp      <= w_qp_init_c;
      end else begin
         if (w_accept) begin
            r_s1_vld  <= 1'b1;
            r_s1_pos  <= w_pos;
            r_s1_mode <= w_mode;
            r_s1_idx  <= w_idx;
         end else if (w_s2_load) begin
            r_s1_vld <= 1'b0;
         end
         if (w_s2_load) begin
            r_out_vld <= 1'b1;
            r_qp      <= w_qp_next;
            out_qp    <= w_qp_next;
            out_delta <= w_delta;
         end else if (out_ready) begin
            r_out_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rc_qp_update.sv
// Directed bench for rc_qp_update: a queue-based reference model checks every output handshake,
// and hand-computed literals pin reset, latency, clamping, config and slice_start behaviour.
module tb_rc_qp_update;

   logic        clk = 1'b0;
   logic        rst, slice_start, in_valid, in_ready, cfg_we, out_valid, out_ready;
   logic [6:0]  qp_init, qp_min, qp_max, out_qp;
   logic [15:0] bits_used, target_bits, rc_fullness;
   logic [5:0]  cfg_addr;
   logic [3:0]  cfg_data, out_delta;

   always #5 clk = ~clk;

   rc_qp_update dut (
      .clk(clk), .rst(rst), .slice_start(slice_start), .qp_init(qp_init), .qp_min(qp_min),
      .qp_max(qp_max), .in_valid(in_valid), .in_ready(in_ready), .bits_used(bits_used),
      .target_bits(target_bits), .rc_fullness(rc_fullness), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .out_valid(out_valid), .out_ready(out_ready), .out_qp(out_qp),
      .out_delta(out_delta));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for handshake", nm);
   endtask

   // ---------------- reference model ----------------
   int INC0 [5][6] = '{'{0,1,2,3,4,5}, '{1,2,3,5,5,6}, '{2,3,4,6,7,7},
                       '{-1,0,1,1,2,2}, '{-2,-1,-1,0,1,1}};
   int DEC0 [5][5] = '{'{0,1,2,3,4}, '{-1,0,0,1,1}, '{-2,-2,0,1,1},
                       '{1,1,2,4,4}, '{2,2,4,5,5}};
   int TPOS [5] = '{10,29,50,60,70};
   int TNEG [4] = '{10,20,35,65};
   int m_inc [5][6];
   int m_dec [5][5];
   int m_qp;
   int q_qp [$];
   int q_dl [$];
   int n_out     = 0;
   int stall_cnt = 0;
   bit stall_prev = 0;
   logic [6:0] prev_qp;
   logic [3:0] prev_dl;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic m_reset();
      m_inc = INC0;
      m_dec = DEC0;
      m_qp  = 0;
      q_qp.delete();
      q_dl.delete();
   endtask

   task automatic m_accept(input int bu, input int tg, input int fu);
      int d, a, mode, idx, dl;
      bit pos;
      d = clampi(bu - tg, -256, 255);
      pos = d > 0;
      a = pos ? d : -d;
      mode = (fu >= 57672) ? 2 : (fu >= 49807) ? 1 : (fu <= 7864) ? 4 : (fu <= 15729) ? 3 : 0;
      idx = 0;
      if (pos) begin
         foreach (TPOS[k]) if (a >= TPOS[k]) idx++;
      end else begin
         foreach (TNEG[k]) if (a >= TNEG[k]) idx++;
      end
      dl = pos ? m_inc[mode][idx] : -m_dec[mode][idx];
      m_qp = clampi(m_qp + dl, int'(qp_min), int'(qp_max));
      q_qp.push_back(m_qp);
      q_dl.push_back(dl & 15);
   endtask

   task automatic m_step();
      int a, v;
      if (rst) begin
         m_reset();
         stall_prev = 0;
         return;
      end
      if (stall_prev) begin
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_qp", 32'(out_qp), 32'(prev_qp));
         chk("stall_dl", 32'(out_delta), 32'(prev_dl));
      end
      if (out_valid && out_ready) begin
         if (q_qp.size() == 0) begin
            timeout("unexpected_output");
         end else begin
            chk("model_qp", 32'(out_qp), q_qp.pop_front());
            chk("model_dl", 32'(out_delta), q_dl.pop_front());
            n_out++;
         end
      end
      stall_prev = out_valid && !out_ready && !slice_start;
      prev_qp = out_qp;
      prev_dl = out_delta;
      if (in_valid && !in_ready) stall_cnt++;
      if (slice_start) begin
         q_qp.delete();
         q_dl.delete();
         m_qp = clampi(int'(qp_init), int'(qp_min), int'(qp_max));
      end else if (in_valid && in_ready) begin
         m_accept(int'(bits_used), int'(target_bits), int'(rc_fullness));
      end
      if (cfg_we) begin
         a = int'(cfg_addr[4:0]);
         v = cfg_data[3] ? int'(cfg_data) - 16 : int'(cfg_data);
         if (!cfg_addr[5] && a < 30) m_inc[a/6][a%6] = v;
         if (cfg_addr[5] && a < 25)  m_dec[a/5][a%5] = v;
      end
   endtask

   // sample one time unit before each rising edge
   always @(negedge clk) begin
      #4;
      m_step();
   end

   // ---------------- drivers (called at negedge) ----------------
   task automatic send(input int bu, input int tg, input int fu, input string nm);
      bits_used   = 16'(bu);
      target_bits = 16'(tg);
      rc_fullness = 16'(fu);
      in_valid    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #4;
         if (in_ready) begin
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      timeout(nm);
   endtask

   task automatic get(input int eqp, input int edl, input string nm);
      for (int i = 0; i < 20; i++) begin
         #4;
         if (out_valid && out_ready) begin
            chk({nm, "_qp"}, 32'(out_qp), eqp);
            chk({nm, "_dl"}, 32'(out_delta), edl);
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      timeout(nm);
   endtask

   task automatic slice(input int qi, input int lo, input int hi);
      qp_init = 7'(qi);
      qp_min  = 7'(lo);
      qp_max  = 7'(hi);
      slice_start = 1'b1;
      @(negedge clk);
      slice_start = 1'b0;
   endtask

   task automatic cfg(input int addr, input int data);
      cfg_addr = 6'(addr);
      cfg_data = 4'(data);
      cfg_we   = 1'b1;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base_out, base_stall;
      int sw_fu [10] = '{60000, 50000, 32768, 12000, 5000, 57672, 49807, 7864, 15729, 57671};
      int sw_d  [10] = '{70, -65, 29, -35, 10, -20, 60, -10, 50, 69};
      rst = 1; slice_start = 0; in_valid = 0; cfg_we = 0; out_ready = 1;
      qp_init = 0; qp_min = 0; qp_max = 127;
      bits_used = 0; target_bits = 0; rc_fullness = 0; cfg_addr = 0; cfg_data = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      #4;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_qp", 32'(out_qp), 0);
      chk("rst_out_delta", 32'(out_delta), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);

      // default path and latency
      slice(30, 0, 127);
      send(120, 100, 32768, "t1_send");
      #4;
      chk("t1_lat_s1", 32'(out_valid), 0);
      @(negedge clk);
      #4;
      chk("t1_lat_out", 32'(out_valid), 1);
      chk("t1_qp", 32'(out_qp), 31);
      chk("t1_dl", 32'(out_delta), 1);
      @(negedge clk);

      // zero and negative path
      slice(30, 0, 127);
      send(100, 100, 32768, "t2a");  get(30, 0, "t2_zero");
      send(60, 100, 32768, "t2b");   get(27, 13, "t2_neg40");

      // mode 4 vs mode 3 rows
      send(180, 100, 5000, "t3a");   get(28, 1, "t3_mode4");
      send(180, 100, 12000, "t3b");  get(30, 2, "t3_mode3");

      // saturation and clamps
      slice(70, 0, 72);
      send(65535, 0, 60000, "t4a");  get(72, 7, "t4_clamp_hi");
      slice(3, 0, 72);
      send(0, 1000, 3000, "t4b");    get(0, 11, "t4_clamp_lo");
      slice(100, 10, 72);
      send(100, 100, 32768, "t4c");  get(72, 0, "t4_init_clamp");

      // backpressure: five back-to-back blocks with a 3-cycle output stall
      slice(40, 0, 127);
      base_out = n_out;
      base_stall = stall_cnt;
      fork
         begin
            send(120, 100, 32768, "t5_b1");
            send(140, 100, 32768, "t5_b2");
            send(85, 100, 32768, "t5_b3");
            send(105, 100, 32768, "t5_b4");
            send(200, 100, 32768, "t5_b5");
         end
         begin
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);
      chk("t5_stalled", 32'(stall_cnt > base_stall), 1);
      chk("t5_count", n_out - base_out, 5);
      chk("t5_final_qp", 32'(out_qp), 47);

      // config write, slice_start flush with simultaneous cfg write
      slice(50, 0, 127);
      cfg(6'h01, 6);
      send(120, 100, 32768, "t6a");  get(56, 6, "t6_cfg");
      send(120, 100, 32768, "t6b");
      qp_init = 7'd20;
      cfg_addr = 6'h02; cfg_data = 4'hD; cfg_we = 1'b1;
      slice_start = 1'b1;
      @(negedge clk);
      slice_start = 1'b0; cfg_we = 1'b0;
      #4;
      chk("t6_flush_valid", 32'(out_valid), 0);
      @(negedge clk);
      send(140, 100, 32768, "t6c");  get(17, 13, "t6_cfg_in_slice");
      send(120, 100, 32768, "t6d");  get(23, 6, "t6_after");

      // reset mid-operation restores defaults
      send(200, 100, 32768, "t7a");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("t7_rst_valid", 32'(out_valid), 0);
      chk("t7_rst_qp", 32'(out_qp), 0);
      @(negedge clk);
      slice(30, 0, 127);
      send(120, 100, 32768, "t7b");  get(31, 1, "t7_default");

      // fullness threshold boundaries
      slice(64, 0, 127);
      send(235, 300, 57672, "t8a");  get(63, 15, "t8_hi2_edge");
      send(370, 300, 57671, "t8b");  get(69, 6, "t8_hi1_side");
      send(290, 300, 7864, "t8c");   get(67, 14, "t8_lo4_edge");

      // sweep checked by the model only
      for (int i = 0; i < 10; i++) send(300 + sw_d[i], 300, sw_fu[i], "t9");
      repeat (5) @(negedge clk);
      chk("queue_empty", q_qp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rc_qp_update.md
Name: rc_qp_update

Overview:
Rate-control QP update engine for the VDC-M encoder. Per coded block it does three things: forms signed diffBits from bits spent versus target, classifies the buffer-fullness mode and threshold index, and looks up a delta QP. It then accumulates the delta into a clamped running QP. The lookup tables are run-time programmable. The block sits between the bit counter and the quantiser, using valid/ready handshakes on both sides.

Parameters:
BITS_W, 16, width of bits_used / target_bits (unsigned)
DIFF_W, 9, width of internal signed diffBits (saturating)
FULL_W, 16, width of rc_fullness (unsigned, full scale = 2^FULL_W)
QP_W, 7, width of QP values (unsigned)
TH_HI2, 57672, fullness >= this -> mode 2
TH_HI1, 49807, fullness >= this -> mode 1
TH_LO4, 7864, fullness <= this -> mode 4
TH_LO3, 15729, fullness <= this -> mode 3

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
slice_start  in  1  pulse: flush pipeline, load qp_init
qp_init  in  QP_W  starting QP for slice
qp_min  in  QP_W  lower QP clamp
qp_max  in  QP_W  upper QP clamp (qp_min <= qp_max)
in_valid  in  1  block statistics valid
in_ready  out  1  block accepted when in_valid && in_ready
bits_used  in  BITS_W  bits spent by block
target_bits  in  BITS_W  target bits for block
rc_fullness  in  FULL_W  buffer fullness
cfg_we  in  1  table write strobe
cfg_addr  in  6  table entry address
cfg_data  in  4  entry value, two's complement
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_qp  out  QP_W  updated QP
out_delta  out  4  applied delta QP, two's complement

Behaviour:
- Reset: out_valid=0, out_qp=0, out_delta=0, S1 valid=0, qp_reg=0. Tables load defaults. in_ready=1 in the first cycle after rst deasserts.
- Stage S1 (registered on accept): diff = bits_used - target_bits, computed in BITS_W+1 bits and saturated to the signed DIFF_W range.
  - Negative path when diff <= 0; zero takes the negative path. abs = |diff|.
  - Mode: fullness >= TH_HI2 -> 2; else >= TH_HI1 -> 1; else <= TH_LO4 -> 4; else <= TH_LO3 -> 3; else 0.
  - Positive path: idx = count of thresholds {10,29,50,60,70} that are <= abs; range 0..5.
  - Negative path: idx = count of thresholds {10,20,35,65} that are <= abs; range 0..4.
- Stage S2 (output register):
  - Positive path: delta = INC[mode][idx]. Negative path: delta = -DEC[mode][idx], mod 16.
  - qp_next = clamp(qp_reg + sext(delta), qp_min, qp_max), computed in QP_W+2 signed bits.
  - On the S1 -> S2 transfer: qp_reg <= qp_next, out_qp <= qp_next, out_delta <= delta (unclamped table value).
  - Every mode, 0 through 4, selects its own table row; no mode aliases another.
- Default INC rows, idx 0..5:
  - m0: 0,1,2,3,4,5
  - m1: 1,2,3,5,5,6
  - m2: 2,3,4,6,7,7
  - m3: -1,0,1,1,2,2
  - m4: -2,-1,-1,0,1,1
- Default DEC rows, idx 0..4:
  - m0: 0,1,2,3,4
  - m1: -1,0,0,1,1
  - m2: -2,-2,0,1,1
  - m3: 1,1,2,4,4
  - m4: 2,2,4,5,5
- Config addressing:
  - cfg_addr[5]=0 selects INC; entry = cfg_addr[4:0] = mode*6+idx, valid 0..29.
  - cfg_addr[5]=1 selects DEC; entry = cfg_addr[4:0] = mode*5+idx, valid 0..24.
  - Out-of-range writes are ignored.
  - A write lands at the clock edge; S2 lookups use the new value from the following cycle.
- Flow control:
  - S2 loads when S1 valid && (!out_valid || out_ready).
  - in_ready = (!S1valid || S2 loads) && !slice_start.
  - Full throughput is 1 block/cycle. Latency is 2 cycles: accepted at edge N, out_valid from edge N+1, i.e. visible the cycle after the S1 edge.
  - While stalled, out_* hold stable.
- slice_start (priority over everything except rst):
  - Clears S1 valid and out_valid.
  - qp_reg <= clamp(qp_init, qp_min, qp_max); out_qp is unchanged.
  - No input is accepted that cycle.
  - A cfg_we in the same cycle is still performed.
- rst mid-operation discards all in-flight blocks and restores the default tables.

Test Plan:
- Default path: qp_init=30, fullness=32768, bits_used=120, target=100 (diff=+20, idx1) -> out_delta=1, out_qp=31, two cycles after accept.
- Negative/zero path: diff=0 with fullness=32768 -> delta 0, qp unchanged. diff=-40 (idx3) -> delta=-3, out_qp=27 from 30.
- Mode 4 distinct: fullness=5000, diff=+80 (idx5) -> delta=+1 (not the m3 value +2). Same diff with fullness=12000 -> +2.
- Clamp and saturation: qp=70, qp_max=72, fullness=60000, bits_used=65535, target=0 (saturated, idx5, m2) -> delta=7, out_qp=72. Symmetric case at qp_min=0 with diff=-1000, fullness=3000 -> out_qp=0.
- Backpressure: 5 back-to-back blocks with out_ready held low for 3 cycles -> in_ready drops after S1 fills, no block is lost or duplicated, and out_qp accumulates in order.
- Config plus slice_start: write INC m0 idx1 = 6 (cfg_addr=0x01), then diff=+20 -> delta 6. Assert slice_start while S1 is valid -> out_valid=0 next cycle, next result based on qp_init.
